// File: rtl/iob_ram_bist_pkg.sv
// Shared types for the single-port RAM BIST.
// Optional inverted second pass is compiled in when IOB_RAM_BIST_INV_EN is defined.
package iob_ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
`ifdef IOB_RAM_BIST_INV_EN
    ,
    StWriteInv,
    StReadInv,
    StDrainInv
`endif
  } state_e;

endpackage

// File: rtl/iob_ram_bist_chk.sv
// Read-data checker: delays expected word and address by one cycle to line up with ram_dout
// and flags a mismatch on the returned word.
module iob_ram_bist_chk #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              mismatch,
  output logic [ADDR_W-1:0] cmp_addr
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      exp_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q <= rd_issue;
      if (rd_issue) begin
        exp_q  <= rd_exp;
        addr_q <= rd_addr;
      end
    end
  end

  assign mismatch = vld_q && (ram_dout != exp_q);
  assign cmp_addr = addr_q;

endmodule

// File: rtl/iob_ram_bist.sv
// RAM BIST initiator: writes an incrementing pattern, reads it back, reports first mismatch.
// Define IOB_RAM_BIST_INV_EN to add a second pass with the bitwise-inverted pattern.
module iob_ram_bist
  import iob_ram_bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 4,
  parameter logic [DATA_W-1:0] SEQ_INI = DATA_W'(32)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [DATA_W-1:0]     fail_data,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + SEQ_INI;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  logic              rd_issue;
  logic [DATA_W-1:0] rd_exp;
  logic              mismatch;
  logic [ADDR_W-1:0] cmp_addr;
  logic              clear_res, set_fail, set_pass;
  logic              last;

  assign last = (addr_q == LastAddr);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_din   = '0;
    rd_issue  = 1'b0;
    rd_exp    = '0;
    clear_res = 1'b0;
    set_fail  = 1'b0;
    set_pass  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StWrite;
          addr_d    = '0;
          clear_res = 1'b1;
        end
      end
      StWrite: begin
        ram_en  = 1'b1;
        ram_we  = '1;
        ram_din = pattern(addr_q);
        addr_d  = addr_q + ADDR_W'(1);
        if (last) state_d = StRead;
      end
      StRead: begin
        // A failing compare stops the read stream in the same cycle.
        ram_en   = !mismatch;
        rd_issue = !mismatch;
        rd_exp   = pattern(addr_q);
        addr_d   = addr_q + ADDR_W'(1);
        if (mismatch) begin
          state_d  = StDone;
          addr_d   = '0;
          set_fail = 1'b1;
        end else if (last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mismatch) begin
          state_d  = StDone;
          set_fail = 1'b1;
        end else begin
`ifdef IOB_RAM_BIST_INV_EN
          state_d  = StWriteInv;
`else
          state_d  = StDone;
          set_pass = 1'b1;
`endif
        end
      end
`ifdef IOB_RAM_BIST_INV_EN
      StWriteInv: begin
        ram_en  = 1'b1;
        ram_we  = '1;
        ram_din = ~pattern(addr_q);
        addr_d  = addr_q + ADDR_W'(1);
        if (last) state_d = StReadInv;
      end
      StReadInv: begin
        ram_en   = !mismatch;
        rd_issue = !mismatch;
        rd_exp   = ~pattern(addr_q);
        addr_d   = addr_q + ADDR_W'(1);
        if (mismatch) begin
          state_d  = StDone;
          addr_d   = '0;
          set_fail = 1'b1;
        end else if (last) begin
          state_d = StDrainInv;
        end
      end
      StDrainInv: begin
        state_d = StDone;
        if (mismatch) set_fail = 1'b1;
        else          set_pass = 1'b1;
      end
`endif
      default: begin
        state_d = StIdle;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_res) begin
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (set_fail) begin
      pass_q      <= 1'b0;
      fail_addr_q <= cmp_addr;
      fail_data_q <= ram_dout;
    end else if (set_pass) begin
      pass_q <= 1'b1;
    end
  end

  iob_ram_bist_chk #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .rd_issue (rd_issue),
    .rd_addr  (addr_q),
    .rd_exp   (rd_exp),
    .ram_dout (ram_dout),
    .mismatch (mismatch),
    .cmp_addr (cmp_addr)
  );

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign ram_addr  = addr_q;

endmodule

// File: tb/tb_iob_ram_bist.sv
// Scoreboard bench for iob_ram_bist with a behavioural byte-enable RAM and fault injection.
module tb_iob_ram_bist;

  localparam int N = 16;
`ifdef IOB_RAM_BIST_INV_EN
  localparam bit InvEn = 1'b1;
`else
  localparam bit InvEn = 1'b0;
`endif
  localparam int DoneCyc = InvEn ? 67 : 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [3:0]  fail_addr;
  logic [31:0] fail_data;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [3:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;

  iob_ram_bist #(
    .DATA_W  (32),
    .ADDR_W  (4),
    .SEQ_INI (32'd32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with injectable read fault and stuck-at-1 byte lane 2.
  logic [31:0] mem [N];
  bit          fault_on = 0;
  bit          fault_inv = 0;
  logic [3:0]  fault_a = '0;
  bit          stuck2 = 0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (start && !busy) wr_cnt <= 0;
    else if (ram_en && ram_we != 4'h0) wr_cnt <= wr_cnt + 1;
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= (stuck2 && b == 2) ? 8'hFF : ram_din[b*8 +: 8];
      if (ram_we == 4'h0)
        ram_dout <= (fault_on && ram_addr == fault_a && ((wr_cnt > N) == fault_inv))
                    ? 32'h0000DEAD : mem[ram_addr];
    end
  end

  typedef struct {logic [3:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic pass; logic [3:0] fa; logic [31:0] fd; int cyc;} res_t;
  wr_t  wq[$];
  res_t rq[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every write and every done assertion against the queues.
  bit done_prev = 0;
  bit count_rd = 0;
  int late_rd = 0;
  always @(negedge clk) begin
    if (ram_en && ram_we != 4'h0) begin
      if (wq.size() == 0) begin
        check_eq("unexpected_write", {28'h0, ram_addr}, 64'hFFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check_eq("wr_addr", {60'h0, ram_addr}, {60'h0, w.addr});
        check_eq("wr_data", {32'h0, ram_din}, {32'h0, w.data});
        check_eq("wr_be", {60'h0, ram_we}, 64'hF);
      end
    end
    if (count_rd && ram_en && ram_we == 4'h0 && ram_addr > 4'd5) late_rd++;
    if (done && !done_prev) begin
      if (rq.size() == 0) begin
        check_eq("unexpected_done", 64'h1, 64'h0);
      end else begin
        res_t r;
        r = rq.pop_front();
        check_eq("pass", {63'h0, pass}, {63'h0, r.pass});
        check_eq("fail_addr", {60'h0, fail_addr}, {60'h0, r.fa});
        check_eq("fail_data", {32'h0, fail_data}, {32'h0, r.fd});
        check_eq("done_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    done_prev = done;
  end

  task automatic push_writes(input int passes);
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < N; a++) begin
        wr_t w;
        w.addr = 4'(a);
        w.data = (p == 0) ? 32'(a + 32) : ~32'(a + 32);
        wq.push_back(w);
      end
  endtask

  task automatic push_res(input logic p, input logic [3:0] fa, input logic [31:0] fd,
                          input int c);
    res_t r;
    r.pass = p; r.fa = fa; r.fd = fd; r.cyc = c;
    rq.push_back(r);
  endtask

  // Returns t0 = cyc value right after the edge that samples start; returns at that time.
  task automatic do_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((rq.size() != 0 || !done) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) check_eq({name, "_timeout"}, 64'(n), 64'h0);
    check_eq({name, "_wq_empty"}, 64'(wq.size()), 64'h0);
  endtask

  int t0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    check_eq("rst_pass", {63'h0, pass}, 64'h0);
    check_eq("rst_fail", {28'h0, fail_addr, fail_data}, 64'h0);
    check_eq("rst_ram", {27'h0, ram_en, ram_we, ram_addr, ram_din}, 64'h0);
    rst = 1'b0;

    // Good RAM
    push_writes(InvEn ? 2 : 1);
    do_start(t0);
    push_res(1'b1, 4'd0, 32'h0, t0 + DoneCyc - 1);
    check_eq("busy_after_start", {63'h0, busy}, 64'h1);
    wait_done("good");
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_held", {62'h0, done, ram_en}, 64'h2);

    // Read fault at addr 5 in the first pass
    fault_on = 1; fault_inv = 0; fault_a = 4'd5;
    late_rd = 0; count_rd = 1;
    push_writes(1);
    do_start(t0);
    push_res(1'b0, 4'd5, 32'h0000DEAD, t0 + N + 7);
    wait_done("fault5");
    count_rd = 0;
    check_eq("no_reads_after_fault", 64'(late_rd), 64'h0);
    fault_on = 0;

    // Reset while writing addr 7
    for (int a = 0; a < 8; a++) begin
      wr_t w;
      w.addr = 4'(a); w.data = 32'(a + 32);
      wq.push_back(w);
    end
    do_start(t0);
    wait_cyc(t0 + 7);
    check_eq("abort_addr", {60'h0, ram_addr}, 64'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_state", {61'h0, ram_en, busy, done}, 64'h0);
    check_eq("abort_wq_empty", 64'(wq.size()), 64'h0);
    push_writes(InvEn ? 2 : 1);
    do_start(t0);
    push_res(1'b1, 4'd0, 32'h0, t0 + DoneCyc - 1);
    wait_done("after_abort");

    // Start during READ is ignored; start from DONE clears done
    push_writes(InvEn ? 2 : 1);
    do_start(t0);
    check_eq("restart_clears_done", {62'h0, done, busy}, 64'h1);
    push_res(1'b1, 4'd0, 32'h0, t0 + DoneCyc - 1);
    wait_cyc(t0 + N + 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("start_in_read");

`ifdef IOB_RAM_BIST_INV_EN
    // Fault at addr 3 during the inverted pass
    fault_on = 1; fault_inv = 1; fault_a = 4'd3;
    push_writes(2);
    do_start(t0);
    push_res(1'b0, 4'd3, 32'h0000DEAD, t0 + 3 * N + 6);
    wait_done("inv_fault3");
    fault_on = 0;
`endif

    // Stuck-at-1 byte lane 2
    stuck2 = 1;
    push_writes(1);
    do_start(t0);
    push_res(1'b0, 4'd0, 32'h00FF0020, t0 + N + 2);
    wait_done("stuck_lane2");
    stuck2 = 0;

    repeat (2) @(posedge clk);
    check_eq("final_rq_empty", 64'(rq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
